// File: rtl/counter_updown_modn.sv
// rtl/counter_updown_modn.sv - up/down modulo-N counter with prescaler, load/clear, wrap or saturate
`timescale 1ns/1ps
module counter_updown_modn #(
  parameter int N        = 6,
  parameter int MODULUS  = 64,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         clear,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         at_limit,
  output logic         overflow
);
  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [N:0]      LAST     = (N+1)'(MODULUS - 1);
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;
  logic [N:0]    cnt_ext;
  logic [N:0]    ld_ext;
  logic [N:0]    limit;
  logic          step;

  always_comb begin
    cnt_ext = {1'b0, count};
    ld_ext  = {1'b0, load_value};
    limit   = up ? LAST : '0;
  end

  assign at_limit = (cnt_ext == limit);
  assign step     = enable && (pre == PRE_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      pre      <= '0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      pre      <= '0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      // Out-of-range loads clamp to the top of the range rather than wrapping.
      count <= (ld_ext > LAST) ? LAST[N-1:0] : load_value;
      pre   <= '0;
      tc    <= 1'b0;
    end else if (step) begin
      pre <= '0;
      if (at_limit) begin
        tc       <= 1'b1;
        overflow <= 1'b1;
        if (SATURATE == 0) begin
          count <= up ? '0 : LAST[N-1:0];
        end
      end else begin
        tc    <= 1'b0;
        count <= N'(up ? (cnt_ext + 1'b1) : (cnt_ext - 1'b1));
      end
    end else begin
      tc <= 1'b0;
      if (enable) begin
        pre <= pre + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_counter_updown_modn.sv
// tb/tb_counter_updown_modn.sv - randomized check of four counter configurations against a behavioural model
`timescale 1ns/1ps
module tb_counter_updown_modn;
  localparam int NI = 4;
  localparam int MODS [NI] = '{64, 10, 64, 60};
  localparam int PRES [NI] = '{1, 1, 1, 4};
  localparam int SATS [NI] = '{0, 0, 1, 0};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] load_value = '0;

  logic [5:0] cnt_o [NI];
  logic       tc_o  [NI];
  logic       lim_o [NI];
  logic       ovf_o [NI];

  int m_cnt [NI];
  int m_pre [NI];
  int m_tc  [NI];
  int m_ovf [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  counter_updown_modn #(.N(6), .MODULUS(64), .PRESCALE(1), .SATURATE(0)) u_wrap64 (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .clear(clear),
    .count(cnt_o[0]), .tc(tc_o[0]), .at_limit(lim_o[0]), .overflow(ovf_o[0]));
  counter_updown_modn #(.N(6), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_wrap10 (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .clear(clear),
    .count(cnt_o[1]), .tc(tc_o[1]), .at_limit(lim_o[1]), .overflow(ovf_o[1]));
  counter_updown_modn #(.N(6), .MODULUS(64), .PRESCALE(1), .SATURATE(1)) u_sat64 (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .clear(clear),
    .count(cnt_o[2]), .tc(tc_o[2]), .at_limit(lim_o[2]), .overflow(ovf_o[2]));
  counter_updown_modn #(.N(6), .MODULUS(60), .PRESCALE(4), .SATURATE(0)) u_pre60 (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .clear(clear),
    .count(cnt_o[3]), .tc(tc_o[3]), .at_limit(lim_o[3]), .overflow(ovf_o[3]));

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end
  endtask

  // Behaviour of one clock edge, straight from the counting rules.
  task automatic model_edge();
    int lim;
    for (int i = 0; i < NI; i++) begin
      if (!reset || clear) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_value) > MODS[i] - 1) ? MODS[i] - 1 : int'(load_value);
        m_pre[i] = 0;
        m_tc[i]  = 0;
      end else begin
        m_tc[i] = 0;
        if (enable) begin
          m_pre[i] = m_pre[i] + 1;
          if (m_pre[i] == PRES[i]) begin
            m_pre[i] = 0;
            lim = up ? MODS[i] - 1 : 0;
            if (m_cnt[i] == lim) begin
              m_tc[i]  = 1;
              m_ovf[i] = 1;
              if (SATS[i] == 0) m_cnt[i] = (m_cnt[i] + (up ? 1 : -1) + MODS[i]) % MODS[i];
            end else begin
              m_cnt[i] = m_cnt[i] + (up ? 1 : -1);
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("count[%0d]", i), int'(cnt_o[i]), m_cnt[i]);
      check($sformatf("tc[%0d]", i), int'(tc_o[i]), m_tc[i]);
      check($sformatf("overflow[%0d]", i), int'(ovf_o[i]), m_ovf[i]);
      check($sformatf("at_limit[%0d]", i), int'(lim_o[i]),
            (m_cnt[i] == (up ? MODS[i] - 1 : 0)) ? 1 : 0);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  // Reset dropped between edges must clear everything before the next edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("async_count[%0d]", i), int'(cnt_o[i]), 0);
      check($sformatf("async_tc[%0d]", i), int'(tc_o[i]), 0);
      check($sformatf("async_ovf[%0d]", i), int'(ovf_o[i]), 0);
    end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (4) tick();
    reset = 1'b1;

    enable = 1'b1; up = 1'b1;
    repeat (64) tick();

    load_value = 6'd3; load = 1'b1; up = 1'b0;
    tick();
    load = 1'b0;
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;

    up = 1'b1;
    repeat (70) tick();
    up = 1'b0;
    tick();

    clear = 1'b1; tick(); clear = 1'b0;
    up = 1'b1;
    repeat (8) tick();
    enable = 1'b0;
    repeat (3) tick();
    enable = 1'b1;
    repeat (4) tick();

    load_value = 6'd63; load = 1'b1;
    tick();
    load_value = 6'd7;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0; load = 1'b0;

    repeat (150) tick();
    async_reset();
    repeat (6) tick();

    for (int k = 0; k < 700; k++) begin
      enable     = ($urandom % 4) != 0;
      load       = ($urandom % 40) == 0;
      clear      = ($urandom % 60) == 0;
      load_value = 6'($urandom);
      if (($urandom % 20) == 0) up = ~up;
      if (($urandom % 120) == 0) async_reset();
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
